// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible-area constants, the RGB444 pixel type and
// the {r,g,b} -> {b,g,r} swizzle used when a stored pixel is sent to the mixer.
package vga_pkg;

    localparam int H_VIS = 640;
    localparam int V_VIS = 480;

    // One pixel as stored in the image ROMs: {r[3:0], g[3:0], b[3:0]}.
    typedef logic [11:0] rgb444_t;

    // The mixer expects {blue, green, red}. ROM words are stored {red, green, blue}.
    function automatic rgb444_t to_bgr(input rgb444_t p);
        return {p[3:0], p[7:4], p[11:8]};
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// N-stage register delay line. It carries per-pixel side information
// (in-window flag, image select, key enable) across the ROM read latency.
module pipe_delay #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (N == 0) begin : g_bypass
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] stage [N];

            // Shift the payload one stage per clock. Every stage clears on reset.
            // NOTE: this is a handful of control flops, not a RAM, so each stage is
            // reset so that no stale in-window flag leaks out after a reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < N; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[N-1];
        end
    endgenerate

endmodule

// File: rtl/img_layer.sv
// Image-window layer for the VGA path. It places an IMG_W x IMG_H picture, read
// from one of N_IMG external ROMs, at (H_OFFSET, V_OFFSET), with optional 2x pixel
// doubling and colour-key transparency. Image select, scale and key enable are
// latched at frame start. The select and key values then travel down the pipe
// with each pixel, so a change never retimes pixels already in flight.
module img_layer
    import vga_pkg::*;
#(
    parameter int      IMG_W    = 160,
    parameter int      IMG_H    = 380,
    parameter int      H_OFFSET = 480,
    parameter int      V_OFFSET = 100,
    parameter int      N_IMG    = 2,
    parameter int      ROM_LAT  = 1,
    parameter rgb444_t KEY      = 12'h000,
    parameter int      ADDR_W   = $clog2(IMG_W * IMG_H),
    localparam int     SEL_W    = (N_IMG > 1) ? $clog2(N_IMG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_count,
    input  logic [8:0]        v_count,
    input  logic [SEL_W-1:0]  sel,
    input  logic              scale2,
    input  logic              key_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [N_IMG*12-1:0] rom_data,
    output rgb444_t           color,
    output logic              active
);

    // Window bounds in 11-bit unsigned space, for 1x and 2x scale.
    localparam logic [10:0] H_LO   = 11'(H_OFFSET);
    localparam logic [10:0] H_END1 = 11'(H_OFFSET + IMG_W);
    localparam logic [10:0] H_END2 = 11'(H_OFFSET + 2 * IMG_W);
    localparam logic [10:0] V_LO   = 11'(V_OFFSET);
    localparam logic [10:0] V_END1 = 11'(V_OFFSET + IMG_H);
    localparam logic [10:0] V_END2 = 11'(V_OFFSET + 2 * IMG_H);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    localparam int PAY_W = SEL_W + 2;

    // Frame-level settings, updated only at frame start
    logic             frame_start;
    logic [SEL_W-1:0] sel_q;
    logic             scale_q;
    logic             key_q;

    // Stage-0 window / address computation
    logic [10:0]       h11, v11, dx, dy, x, y;
    logic              in_h, in_v, in_win;
    logic [ADDR_W-1:0] addr_next;

    // Stage-0 registers and the delayed copies aligned with rom_data
    logic             win_s0, key_s0;
    logic [SEL_W-1:0] sel_s0;
    logic             win_d, key_d;
    logic [SEL_W-1:0] sel_d;

    // Output stage
    rgb444_t pix;
    logic    active_next;

    assign frame_start = (h_count == 10'd0) && (v_count == 9'd0);

    // Latch select, scale and key enable at frame start. Out-of-range selects are ignored.
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            scale_q <= 1'b0;
            key_q   <= 1'b0;
        end else if (frame_start) begin
            if (32'(sel) < N_IMG) sel_q <= sel;
            scale_q <= scale2;
            key_q   <= key_en;
        end
    end

    // Window test and ROM address. A coordinate below an offset is simply outside,
    // so the wrapped difference in that case is never used.
    always_comb begin
        h11       = {1'b0, h_count};
        v11       = {2'b0, v_count};
        dx        = h11 - H_LO;
        dy        = v11 - V_LO;
        in_h      = (h11 >= H_LO) && (h11 < (scale_q ? H_END2 : H_END1));
        in_v      = (v11 >= V_LO) && (v11 < (scale_q ? V_END2 : V_END1));
        in_win    = in_h && in_v;
        x         = scale_q ? (dx >> 1) : dx;
        y         = scale_q ? (dy >> 1) : dy;
        addr_next = ADDR_W'(y) * IMG_W_A + ADDR_W'(x);
    end

    // Stage 0: register the ROM address (held outside the window) and the pixel's side info.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            win_s0   <= 1'b0;
            sel_s0   <= '0;
            key_s0   <= 1'b0;
        end else begin
            win_s0 <= in_win;
            sel_s0 <= sel_q;
            key_s0 <= key_q;
            if (in_win) rom_addr <= addr_next;
        end
    end

    // Carry the side info across the ROM read latency so it lines up with rom_data.
    pipe_delay #(
        .W (PAY_W),
        .N (ROM_LAT)
    ) u_side_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({win_s0, sel_s0, key_s0}),
        .q     ({win_d, sel_d, key_d})
    );

    // Pick the selected ROM's word and apply the colour key.
    // NOTE: pix gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        pix = '0;
        for (int i = 0; i < N_IMG; i++) begin
            if (32'(sel_d) == i) pix = rom_data[12*i +: 12];
        end
        active_next = win_d && !(key_d && (pix == KEY));
    end

    // Final stage: register the visibility flag and the swizzled colour (0 when inactive).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            color  <= '0;
        end else begin
            active <= active_next;
            color  <= active_next ? to_bgr(pix) : '0;
        end
    end

endmodule

// File: tb/tb_img_layer.sv
// Scoreboard bench for img_layer. The driver applies one (h,v) per clock, works out
// the expected rom_addr and color/active from its own model of the window and ROM
// contents, and queues them with the cycle they are due. A monitor samples just
// after every rising edge and pops whatever is due. Three ROMs are attached so the
// 2-bit select has one unused code (3) to exercise the out-of-range case.
module tb_img_layer;

    localparam int N_IMG   = 3;
    localparam int ROM_LAT = 1;
    localparam int ADDR_W  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  h_count = '0;
    logic [8:0]  v_count = '0;
    logic [1:0]  sel = '0;
    logic        scale2 = 1'b0;
    logic        key_en = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [N_IMG*12-1:0] rom_data = '0;
    logic [11:0] color;
    logic        active;

    always #5 clk = ~clk;

    img_layer #(
        .N_IMG   (N_IMG),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .h_count  (h_count),
        .v_count  (v_count),
        .sel      (sel),
        .scale2   (scale2),
        .key_en   (key_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .color    (color),
        .active   (active)
    );

    // ROM contents: image 0 has a key-coloured pixel at 5 and a green one at 6.
    function automatic logic [11:0] img_word(input int k, input logic [15:0] a);
        logic [15:0] t;
        case (k)
            0: begin
                if (a == 16'd5) return 12'h000;
                if (a == 16'd6) return 12'h0F0;
                t = a * 16'd7 + 16'h123;
                return t[11:0];
            end
            1:       return a[11:0] ^ 12'hABC;
            default: return a[11:0] + 12'h321;
        endcase
    endfunction

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk)
        rom_data <= {img_word(2, rom_addr), img_word(1, rom_addr), img_word(0, rom_addr)};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              due;
        logic [ADDR_W-1:0] addr;
        logic            act;
        logic [11:0]     col;
        string           tag;
    } exp_t;

    exp_t addr_q[$];
    exp_t pix_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state mirroring the frame-level settings and the held address.
    int          m_sel = 0;
    logic        m_scale = 1'b0;
    logic        m_key = 1'b0;
    logic [15:0] m_addr = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: compare whatever is due, just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
                e = addr_q.pop_front();
                check({e.tag, " rom_addr"}, 32'(rom_addr), 32'(e.addr));
            end
            while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
                e = pix_q.pop_front();
                check({e.tag, " active"}, 32'(active), 32'(e.act));
                check({e.tag, " color"},  32'(color),  32'(e.col));
            end
        end
    end

    // Apply one pixel coordinate and queue its expected address and output.
    task automatic drive(input string tag, input int h, input int v);
        int          h_end, v_end, x, y;
        logic        win, act;
        logic [11:0] pix, col;
        @(negedge clk);
        rst_n   = 1'b1;
        h_count = 10'(h);
        v_count = 9'(v);
        h_end = m_scale ? 480 + 320 : 480 + 160;
        v_end = m_scale ? 100 + 760 : 100 + 380;
        win   = (h >= 480) && (h < h_end) && (v >= 100) && (v < v_end);
        if (win) begin
            x = m_scale ? (h - 480) / 2 : (h - 480);
            y = m_scale ? (v - 100) / 2 : (v - 100);
            m_addr = 16'(y * 160 + x);
        end
        pix = img_word(m_sel, m_addr);
        act = win && !(m_key && pix == 12'h000);
        col = act ? {pix[3:0], pix[7:4], pix[11:8]} : 12'h000;
        addr_q.push_back('{due: cyc + 1, addr: m_addr, act: 1'b0, col: 12'h000, tag: tag});
        pix_q.push_back('{due: cyc + 3, addr: m_addr, act: act, col: col, tag: tag});
        if (h == 0 && v == 0) begin
            if (sel < 2'd3) m_sel = int'(sel);
            m_scale = scale2;
            m_key   = key_en;
        end
    endtask

    // Hold reset for n cycles with the counters moving; everything must read zero.
    task automatic reset_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            addr_q.delete();
            pix_q.delete();
            h_count = 10'(490 + i);
            v_count = 9'd110;
            addr_q.push_back('{due: cyc + 1, addr: '0, act: 1'b0, col: 12'h000, tag: tag});
            pix_q.push_back('{due: cyc + 1, addr: '0, act: 1'b0, col: 12'h000, tag: tag});
        end
        m_sel   = 0;
        m_scale = 1'b0;
        m_key   = 1'b0;
        m_addr  = '0;
    endtask

    // Watchdog: the stimulus is finite, this only guards against a stuck simulator.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with counters running
        reset_cycles("reset", 6);

        // Frame start, scale off, key off, image 0
        sel = 2'd0; scale2 = 1'b0; key_en = 1'b0;
        drive("frame0", 0, 0);
        drive("first_pixel", 480, 100);      // addr 0, color 0x321
        drive("second_pixel", 481, 100);
        drive("last_pixel", 639, 479);       // addr 159+379*160 = 60799
        drive("left_edge", 479, 100);
        drive("right_edge", 640, 100);
        drive("top_edge", 480, 99);
        drive("bottom_edge", 480, 480);
        drive("last_line", 480, 479);        // addr 60640
        drive("nokey_black", 485, 100);      // key off: black pixel visible
        drive("nokey_green", 486, 100);

        // Select change mid-frame only takes effect at the next frame start
        sel = 2'd1;
        drive("sel_midframe", 480, 100);     // still image 0
        drive("frame1", 0, 0);
        drive("img1_pixel", 480, 100);       // 0xABC swizzled -> 0xCBA
        sel = 2'd3;
        drive("frame_bad_sel", 0, 0);
        drive("img1_after_bad_sel", 481, 101);

        // Colour key
        sel = 2'd0; key_en = 1'b1;
        drive("frame_key", 0, 0);
        drive("key_pixel", 485, 100);        // 0x000 -> transparent
        drive("key_neighbour", 486, 100);    // 0x0F0 -> visible
        drive("key_other", 490, 105);

        // 2x scale
        key_en = 1'b0; scale2 = 1'b1;
        drive("frame_scale", 0, 0);
        drive("scale_addr", 483, 103);       // addr 1*160+1 = 161
        drive("scale_right", 799, 100);      // x=159, still inside
        drive("scale_left0", 0, 100);
        drive("scale_left479", 479, 100);
        drive("scale_bottom", 480, 511);     // y=205 -> addr 32800
        scale2 = 1'b0;
        drive("scale_midframe", 799, 100);   // still 2x until frame start
        drive("frame_unscale", 0, 0);
        drive("unscale_right", 799, 100);    // now outside

        // Reset mid-frame: pipe clears, select falls back to image 0
        sel = 2'd2;
        drive("frame_img2", 0, 0);
        drive("img2_pixel", 490, 110);
        drive("img2_pixel_b", 491, 110);
        reset_cycles("midframe_reset", 2);
        drive("post_reset", 480, 100);       // image 0 again, sel input ignored
        drive("post_reset_b", 482, 101);

        // Let the last expectations drain
        repeat (6) @(negedge clk);
        n_cmp++;
        if (addr_q.size() != 0 || pix_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d addr and %0d pixel checks never reached", addr_q.size(), pix_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
